// File: rtl/ddr_port_arbiter_pkg.sv
// ddr_port_arbiter_pkg: requester indices, app command encodings and arbiter helpers
package ddr_port_arbiter_pkg;
  localparam int NUM_REQ = 5;
  localparam logic [2:0] REQ_CAPTURE = 3'd0;
  localparam logic [2:0] REQ_ADC = 3'd1;
  localparam logic [2:0] REQ_LA = 3'd2;
  localparam logic [2:0] REQ_TRACE = 3'd3;
  localparam logic [2:0] REQ_SINGLE = 3'd4;
  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ = 3'b001;
  typedef enum logic {IDLE, ISSUE} arb_state_t;
  function automatic logic [NUM_REQ-1:0] req_onehot(input logic [2:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction
  // round-robin successor within the stream readers 1..3
  function automatic logic [2:0] rr_next(input logic [2:0] p);
    return p == REQ_TRACE ? REQ_ADC : p + 3'd1;
  endfunction
endpackage

// File: rtl/ddr_port_arbiter_tag_fifo.sv
// ddr_arb_tag_fifo: in-order FIFO of 3-bit requester tags for outstanding reads
module ddr_arb_tag_fifo #(
  parameter int pDEPTH = 16
)(
  input  logic       ui_clk,
  input  logic       reset_i,
  input  logic       push,
  input  logic [2:0] din,
  input  logic       pop,
  output logic [2:0] dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(pDEPTH);
  logic [2:0] mem [pDEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  assign full = count == (AW+1)'(pDEPTH);
  assign empty = count == '0;
  assign dout = mem[rd_ptr];
  always_ff @(posedge ui_clk or posedge reset_i)
    if (reset_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge ui_clk)
    if (push) mem[wr_ptr] <= din;
endmodule

// File: rtl/ddr_port_arbiter.sv
// ddr_port_arbiter: shares the DDR app command port among five requesters, steering read data by tag.
// Optional DDR_ARB_STATS_EN adds per-requester stall maxima (stall_max_o, stats_clear_i).
module ddr_port_arbiter
  import ddr_port_arbiter_pkg::*;
#(
  parameter int pADDR_W = 30,
  parameter int pMAX_BURST = 16,
  parameter int pTAG_DEPTH = 16,
  parameter int pSTARVE = 64
)(
  input  logic                       ui_clk,
  input  logic                       reset_i,
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [NUM_REQ*pADDR_W-1:0] addr_i,
  input  logic                       single_rnw_i,
  output logic                       app_en_o,
  output logic [2:0]                 app_cmd_o,
  output logic [pADDR_W-1:0]         app_addr_o,
  input  logic                       app_rdy_i,
  input  logic                       app_wdf_rdy_i,
  input  logic                       app_rd_data_valid_i,
  output logic [NUM_REQ-1:0]         grant_o,
  output logic [NUM_REQ-1:0]         cmd_ack_o,
  output logic [NUM_REQ-1:0]         rd_valid_o,
  output logic                       busy_o,
  output logic                       rd_unexpected_o,
  input  logic                       clear_errors_i
`ifdef DDR_ARB_STATS_EN
  ,input logic                       stats_clear_i,
  output logic [NUM_REQ*16-1:0]      stall_max_o
`endif
);
  localparam int SW = $clog2(pSTARVE + 1);
  arb_state_t state;
  logic [2:0] g, win, rr_ptr, rr_a, rr_b, rr_c, tag_head;
  logic [7:0] burst_cnt;
  logic [SW-1:0] starve_cnt;
  logic issue, is_rd, gate, accept, pop, tag_full, tag_empty;
  always_comb begin
    rr_a = rr_next(rr_ptr);
    rr_b = rr_next(rr_a);
    rr_c = rr_next(rr_b);
    win = (req_i[REQ_SINGLE] && starve_cnt == SW'(pSTARVE)) ? REQ_SINGLE :
          req_i[REQ_CAPTURE] ? REQ_CAPTURE :
          req_i[rr_a] ? rr_a : req_i[rr_b] ? rr_b : req_i[rr_c] ? rr_c : REQ_SINGLE;
    issue = state == ISSUE;
    is_rd = g == REQ_SINGLE ? single_rnw_i : g != REQ_CAPTURE;
    // a same-cycle pop frees a slot, so a full FIFO still admits the read
    gate = is_rd ? (~tag_full | app_rd_data_valid_i) : app_wdf_rdy_i;
    app_en_o = issue & req_i[g] & gate;
    accept = app_en_o & app_rdy_i;
    app_cmd_o = issue & is_rd ? CMD_READ : CMD_WRITE;
    app_addr_o = issue ? addr_i[g*pADDR_W +: pADDR_W] : '0;
    cmd_ack_o = accept ? req_onehot(g) : '0;
    pop = app_rd_data_valid_i & ~tag_empty;
    rd_valid_o = pop ? req_onehot(tag_head) : '0;
    busy_o = issue | ~tag_empty;
  end
  ddr_arb_tag_fifo #(.pDEPTH(pTAG_DEPTH)) u_tag_fifo (
    .ui_clk(ui_clk),
    .reset_i(reset_i),
    .push(accept & is_rd),
    .din(g),
    .pop(pop),
    .dout(tag_head),
    .full(tag_full),
    .empty(tag_empty)
  );
  always_ff @(posedge ui_clk or posedge reset_i)
    if (reset_i) begin
      state <= IDLE;
      g <= '0;
      grant_o <= '0;
      rr_ptr <= REQ_TRACE;
      burst_cnt <= '0;
      starve_cnt <= '0;
      rd_unexpected_o <= 1'b0;
    end else begin
      starve_cnt <= grant_o[REQ_SINGLE] ? '0 :
                    (req_i[REQ_SINGLE] && starve_cnt != SW'(pSTARVE)) ? starve_cnt + 1'b1 : starve_cnt;
      rd_unexpected_o <= (app_rd_data_valid_i & tag_empty) | (rd_unexpected_o & ~clear_errors_i);
      if (!issue) begin
        if (|req_i) begin
          state <= ISSUE;
          g <= win;
          grant_o <= req_onehot(win);
        end
      end else if ((accept && burst_cnt == 8'(pMAX_BURST - 1)) || !req_i[g]) begin
        state <= IDLE;
        grant_o <= '0;
        burst_cnt <= '0;
        if (g != REQ_CAPTURE && g != REQ_SINGLE) rr_ptr <= g;
      end else if (accept) burst_cnt <= burst_cnt + 1'b1;
    end
  // requesters must hold request and address from app_en_o until their ack
  a_req_hold: assert property (@(posedge ui_clk) disable iff (reset_i)
    app_en_o && !app_rdy_i |=> req_i[$past(g)] && $stable(app_addr_o));
`ifdef DDR_ARB_STATS_EN
  for (genvar n = 0; n < NUM_REQ; n++) begin : g_stat
    logic [15:0] cur, mx, nxt;
    logic stalled;
    assign stalled = req_i[n] & ~cmd_ack_o[n];
    assign nxt = cur == 16'hFFFF ? cur : cur + 16'd1;
    assign stall_max_o[n*16 +: 16] = mx;
    always_ff @(posedge ui_clk or posedge reset_i)
      if (reset_i) begin
        cur <= '0;
        mx <= '0;
      end else begin
        cur <= stalled ? nxt : '0;
        mx <= stats_clear_i ? '0 : (stalled && nxt > mx) ? nxt : mx;
      end
  end
`endif
endmodule

// File: tb/tb_ddr_port_arbiter.sv
// tb_ddr_port_arbiter: directed and randomized checks of ddr_port_arbiter against a queue-based reference model
module tb_ddr_port_arbiter;
  localparam int AW = 30, MB = 16, TD = 16, ST = 64;
  logic ui_clk = 0, reset_i = 1;
  logic [4:0] req = '0;
  logic [5*AW-1:0] addr = '0;
  logic single_rnw = 0, rdy = 0, wdf = 0, rdv = 0, clr = 0;
  logic app_en_o, busy_o, rd_unexpected_o;
  logic [2:0] app_cmd_o;
  logic [AW-1:0] app_addr_o;
  logic [4:0] grant_o, cmd_ack_o, rd_valid_o;
  int checks = 0, failures = 0;
  int m_owner, m_burst, m_rr, m_starve;
  bit m_unexp, drain;
  int tq[$];
  bit lock[5];
  int ack_seen[5], rd_seen[5];

  always #5 ui_clk = ~ui_clk;

  ddr_port_arbiter #(.pADDR_W(AW), .pMAX_BURST(MB), .pTAG_DEPTH(TD), .pSTARVE(ST)) dut (
    .ui_clk(ui_clk), .reset_i(reset_i), .req_i(req), .addr_i(addr), .single_rnw_i(single_rnw),
    .app_en_o(app_en_o), .app_cmd_o(app_cmd_o), .app_addr_o(app_addr_o), .app_rdy_i(rdy),
    .app_wdf_rdy_i(wdf), .app_rd_data_valid_i(rdv), .grant_o(grant_o), .cmd_ack_o(cmd_ack_o),
    .rd_valid_o(rd_valid_o), .busy_o(busy_o), .rd_unexpected_o(rd_unexpected_o), .clear_errors_i(clr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_burst = 0; m_rr = 3; m_starve = 0; m_unexp = 0;
    tq.delete();
    for (int n = 0; n < 5; n++) lock[n] = 0;
  endtask

  task automatic zero_check(input string tag);
    chk({tag, "_grant"}, grant_o, 0);
    chk({tag, "_en"}, app_en_o, 0);
    chk({tag, "_cmd"}, app_cmd_o, 0);
    chk({tag, "_addr"}, app_addr_o, 0);
    chk({tag, "_ack"}, cmd_ack_o, 0);
    chk({tag, "_rdv"}, rd_valid_o, 0);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_unexp"}, rd_unexpected_o, 0);
  endtask

  function automatic int winner();
    if (req[4] && m_starve >= ST) return 4;
    if (req[0]) return 0;
    for (int k = 1; k <= 3; k++) begin
      int c = (m_rr - 1 + k) % 3 + 1;
      if (req[c]) return c;
    end
    return 4;
  endfunction

  // one clock cycle: compare at the falling edge, then advance the model to the rising edge
  task automatic step();
    int g, ns;
    bit issue, is_rd, gate, en, acc, nu;
    @(negedge ui_clk);
    issue = m_owner >= 0;
    g = issue ? m_owner : 0;
    is_rd = g == 4 ? single_rnw : g != 0;
    gate = is_rd ? (tq.size() < TD || rdv) : wdf;
    en = issue && req[g] && gate;
    acc = en && rdy;
    chk("grant", grant_o, issue ? 64'(1) << g : 0);
    chk("app_en", app_en_o, en);
    chk("app_cmd", app_cmd_o, issue && is_rd ? 1 : 0);
    chk("app_addr", app_addr_o, issue ? 64'(addr[g*AW +: AW]) : 0);
    chk("cmd_ack", cmd_ack_o, acc ? 64'(1) << g : 0);
    chk("rd_valid", rd_valid_o, (rdv && tq.size() > 0) ? 64'(1) << tq[0] : 0);
    chk("busy", busy_o, issue || tq.size() > 0);
    chk("rd_unexp", rd_unexpected_o, m_unexp);
    for (int n = 0; n < 5; n++) begin
      ack_seen[n] += int'(cmd_ack_o[n]);
      rd_seen[n] += int'(rd_valid_o[n]);
    end
    if (en && !rdy) lock[g] = 1;
    if (acc) lock[g] = 0;
    nu = (rdv && tq.size() == 0) ? 1 : clr ? 0 : m_unexp;
    if (rdv && tq.size() > 0) void'(tq.pop_front());
    if (acc && is_rd) tq.push_back(g);
    m_unexp = nu;
    ns = m_owner == 4 ? 0 : (req[4] && m_starve < ST) ? m_starve + 1 : m_starve;
    if (!issue) begin
      if (req != 0) begin m_owner = winner(); m_burst = 0; end
    end else if ((acc && m_burst == MB - 1) || !req[g]) begin
      if (g >= 1 && g <= 3) m_rr = g;
      m_owner = -1; m_burst = 0;
    end else if (acc) m_burst++;
    m_starve = ns;
    @(posedge ui_clk);
    #1;
  endtask

  task automatic clear_seen();
    for (int n = 0; n < 5; n++) begin ack_seen[n] = 0; rd_seen[n] = 0; end
  endtask

  task automatic run(input int cycles);
    for (int i = 0; i < cycles; i++) begin
      if (drain) rdv = tq.size() > 0;
      step();
    end
  endtask

  initial begin
    int wait_n;
    bit got;
    model_reset();
    for (int n = 0; n < 5; n++) addr[n*AW +: AW] = AW'(32'h100 * (n + 1));
    #1 zero_check("reset");
    #20 @(posedge ui_clk);
    #1 reset_i = 0;
    // single ADC requester: one full burst fills the tag FIFO, then reads drain in order
    clear_seen();
    rdy = 1; wdf = 1; req = 5'b00010;
    step();
    chk("first_grant", grant_o, 5'b00010);
    run(19);
    chk("burst_acks", ack_seen[1], MB);
    chk("full_regrant", grant_o, 5'b00010);
    chk("full_stall_en", app_en_o, 0);
    req = 0; rdv = 1;
    run(16);
    chk("replay_count", rd_seen[1], TD);
    chk("drained_busy", busy_o, 0);
    step();
    chk("unexp_set", rd_unexpected_o, 1);
    rdv = 0; clr = 1;
    step();
    clr = 0;
    chk("unexp_clear", rd_unexpected_o, 0);
    // capture write arrives mid-burst of LA: LA finishes, capture wins next
    clear_seen();
    drain = 1; req = 5'b00100;
    run(5);
    req[0] = 1;
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin run(1); got = grant_o[0]; end
    chk("capture_granted", got, 1);
    chk("la_burst_done", ack_seen[2], MB);
    wdf = 0;
    run(2);
    chk("wdf_hold_en", app_en_o, 0);
    chk("wdf_hold_ack", cmd_ack_o, 0);
    req = 0; wdf = 1;
    run(4);
    // single access starves behind continuous ADC reads
    req = 5'b10010; single_rnw = 0;
    wait_n = 0; got = 0;
    for (int i = 0; i < 200 && !got; i++) begin run(1); wait_n++; got = grant_o[4]; end
    chk("starve_granted", got, 1);
    chk("starve_bound", wait_n <= ST + MB + 4, 1);
    chk("single_write_cmd", app_cmd_o, 3'b000);
    chk("single_write_en", app_en_o, 1);
    req = 0;
    run(6);
    // asynchronous reset in the middle of a read burst
    drain = 0; rdv = 0; req = 5'b00010;
    run(5);
    #2 reset_i = 1;
    #1 zero_check("mid_reset");
    model_reset();
    req = 0;
    @(posedge ui_clk);
    #1 reset_i = 0;
    rdv = 1;
    step();
    chk("post_reset_unexp", rd_unexpected_o, 1);
    rdv = 0; clr = 1;
    step();
    clr = 0;
    // randomized traffic honouring the hold-until-ack rule
    for (int i = 0; i < 3000; i++) begin
      for (int n = 0; n < 5; n++)
        if (!lock[n]) begin
          req[n] = $urandom_range(0, 2) != 0;
          addr[n*AW +: AW] = AW'($urandom);
        end
      if (!lock[4]) single_rnw = $urandom_range(0, 1) == 1;
      rdy = $urandom_range(0, 3) != 0;
      wdf = $urandom_range(0, 3) != 0;
      rdv = $urandom_range(0, 2) == 0;
      clr = $urandom_range(0, 15) == 0;
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
